// File: rtl/regex_stream_ctx.sv
// -----------------------------------------------------------------------------
// regex_stream_ctx
// Per-stream context manager for one DFA regex matcher. Saves matcher state per
// stream ID at packet commit and restores it at packet start, keeps a valid bit
// per stream, counts matching packets (saturating) and flags protocol misuse.
//
// Optional feature macro: REGEX_CTX_PER_STREAM_CNT_EN
//   defined   : per-stream match counters (scnt_mem) with registered rd_sid read
//               port, zeroed by the CLEAR sweep.
//   undefined : rd_cnt tied to 0, rd_sid ignored; CLEAR still sweeps vld.
//
// Ports
//   clk, rst_n       clock, async active-low reset
//   load_state       packet-start strobe (samples stream_id, new_stream_id)
//   stream_id        stream of the current packet
//   new_stream_id    force a fresh context (state 0)
//   enable           regex enabled for this stream, sampled at eop
//   eop / abort      commit / discard the current packet (abort wins)
//   clr_stats        start the statistics clear sweep
//   m_state_in(_vld) restore state and one-cycle strobe to the matcher
//   m_state_out      current matcher state, saved at an enabled eop
//   m_accept         matcher accept
//   fired            match seen in the current packet
//   count            global committed-packet match count
//   rd_sid / rd_cnt  per-stream count read (one-cycle latency)
//   busy             high during LOAD or CLEAR
//   proto_err        sticky protocol-error flag
// -----------------------------------------------------------------------------
module regex_stream_ctx #(
  parameter int STATE_W = 11,
  parameter int SID_W   = 6,
  parameter int CNT_W   = 16
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               load_state,
  input  logic [SID_W-1:0]   stream_id,
  input  logic               new_stream_id,
  input  logic               enable,
  input  logic               eop,
  input  logic               abort,
  input  logic               clr_stats,
  output logic [STATE_W-1:0] m_state_in,
  output logic               m_state_in_vld,
  input  logic [STATE_W-1:0] m_state_out,
  input  logic               m_accept,
  output logic               fired,
  output logic [CNT_W-1:0]   count,
  input  logic [SID_W-1:0]   rd_sid,
  output logic [CNT_W-1:0]   rd_cnt,
  output logic               busy,
  output logic               proto_err
);

  localparam int               DEPTH    = 1 << SID_W;
  localparam logic [SID_W-1:0] LAST_IDX = SID_W'(DEPTH - 1);
  localparam logic [CNT_W-1:0] CNT_MAX  = '1;

  typedef enum logic [1:0] {IDLE, LOAD, RUN, CLEAR} ctx_state_e;

  ctx_state_e         state;
  logic [SID_W-1:0]   sid_q;
  logic [SID_W-1:0]   clr_idx;
  logic [DEPTH-1:0]   vld;
  logic [STATE_W-1:0] state_mem [DEPTH];

  logic               fired_eff;
  logic               end_pkt;
  logic               commit;
  logic               proto_hit;
  logic [STATE_W-1:0] restore;

  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v,
                                                input logic             inc);
    return (inc && (v != CNT_MAX)) ? v + CNT_W'(1) : v;
  endfunction

  // NOTE: every signal written in always_comb gets a value on every path
  // (defaults first), otherwise synthesis infers a latch.
  always_comb begin
    fired_eff = fired | m_accept;
    end_pkt   = (state == RUN) && (eop || abort);
    commit    = (state == RUN) && eop && !abort && enable;

    proto_hit = 1'b0;
    case (state)
      IDLE:  proto_hit = eop || abort;
      LOAD:  proto_hit = eop || abort || load_state;
      RUN:   proto_hit = load_state && !(eop || abort);
      CLEAR: proto_hit = load_state || eop || abort || clr_stats;
      default: proto_hit = 1'b0;
    endcase

    // Restore value for a load sampled this cycle. A commit to the same stream
    // in this very cycle has not reached state_mem/vld yet, so forward it.
    restore = '0;
    if (new_stream_id)
      restore = '0;
    else if (commit && (stream_id == sid_q))
      restore = m_state_out;
    else if (vld[stream_id])
      restore = state_mem[stream_id];
  end

  // NOTE: sequential state uses non-blocking assignments only, so every flop
  // samples the pre-edge values regardless of statement order.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state          <= IDLE;
      sid_q          <= '0;
      clr_idx        <= '0;
      vld            <= '0;
      m_state_in     <= '0;
      m_state_in_vld <= 1'b0;
      fired          <= 1'b0;
      count          <= '0;
      busy           <= 1'b0;
      proto_err      <= 1'b0;
    end else begin
      m_state_in_vld <= 1'b0;
      case (state)
        IDLE: begin
          if (load_state) begin
            state          <= LOAD;
            sid_q          <= stream_id;
            m_state_in     <= restore;
            m_state_in_vld <= 1'b1;
            busy           <= 1'b1;
          end else if (clr_stats) begin
            state   <= CLEAR;
            clr_idx <= '0;
            busy    <= 1'b1;
          end
        end
        LOAD: begin
          fired <= 1'b0;
          state <= RUN;
          busy  <= 1'b0;
        end
        RUN: begin
          if (m_accept)
            fired <= 1'b1;
          if (end_pkt) begin
            if (commit) begin
              vld[sid_q] <= 1'b1;
              count      <= sat_inc(count, fired_eff);
            end else begin
              fired <= 1'b0;
            end
            // Back-to-back packet: the old one is committed above, the new
            // one starts its LOAD in the same edge.
            if (load_state) begin
              state          <= LOAD;
              sid_q          <= stream_id;
              m_state_in     <= restore;
              m_state_in_vld <= 1'b1;
              busy           <= 1'b1;
            end else begin
              state <= IDLE;
            end
          end
        end
        CLEAR: begin
          vld[clr_idx] <= 1'b0;
          if (clr_idx == '0) begin
            count     <= '0;
            proto_err <= 1'b0;
          end
          if (clr_idx == LAST_IDX) begin
            state <= IDLE;
            busy  <= 1'b0;
          end else begin
            clr_idx <= clr_idx + SID_W'(1);
          end
        end
        default: state <= IDLE;
      endcase
      // Misuse seen in the same cycle as the sweep's first entry still sticks.
      if (proto_hit)
        proto_err <= 1'b1;
    end
  end

  // NOTE: context memories carry no reset; stale entries are masked by vld
  // and per-stream counters are zeroed by the CLEAR sweep.
  always_ff @(posedge clk) begin
    if (commit)
      state_mem[sid_q] <= m_state_out;
  end

`ifdef REGEX_CTX_PER_STREAM_CNT_EN
  logic [CNT_W-1:0] scnt_mem [DEPTH];

  always_ff @(posedge clk) begin
    if (state == CLEAR)
      scnt_mem[clr_idx] <= '0;
    else if (commit)
      scnt_mem[sid_q] <= sat_inc(scnt_mem[sid_q], fired_eff);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)
      rd_cnt <= '0;
    else
      rd_cnt <= scnt_mem[rd_sid];
  end
`else
  logic unused_rd_sid;
  assign unused_rd_sid = ^rd_sid;
  assign rd_cnt        = '0;
`endif

endmodule
